mbrt_rot_pipe: RTL
==================

MBRT_ROT_PIPE -- requirements
Module: mbrt_rot_pipe

Interface
REQ-001 SHALL have parameter CW, default 20, meaning coarse/output word width (signed).
REQ-002 SHALL have parameter FW, default 12, meaning fine offset width (signed).
REQ-003 SHALL have parameter SEGW, default 3, meaning per-stage rotation segment width (signed).
REQ-004 SHALL have parameter NSTG, default 3, meaning rotation stage count (1..6).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  input sample valid.
REQ-008 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-009 SHALL have port lut_data  input  2*CW+2*FW  packed {xc,yc,xp,yp}, MSB first.
REQ-010 SHALL have port phi_rot  input  NSTG*SEGW  segment k = phi_rot[k*SEGW +: SEGW].
REQ-011 SHALL have port en  input  NSTG  per-stage enable, sampled with the input.
REQ-012 SHALL have port out_valid  output  1  xs/ys valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts output.
REQ-014 SHALL have ports xs, ys  output  CW each  rotated signed result.

Function
REQ-015 Transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 xp, yp SHALL be sign-extended to CW bits; phi_k SHALL be signed two's complement.
REQ-017 Stage 0 input SHALL be (x,y) = (xc,yc); xp, yp, phi, en SHALL travel with the sample through every stage register.
REQ-018 Enabled stage k SHALL compute x' = x - ((yp*phi_k) >>> SEGW*(k+2)), y' = y + ((xp*phi_k) >>> SEGW*(k+2)); products FW+SEGW bits, arithmetic (floor) shift.
REQ-019 Disabled stage SHALL pass (x,y) unchanged.
REQ-020 Latency SHALL be exactly NSTG+1 cycles from input transfer to out_valid, absent stalls.
REQ-021 Pipeline SHALL stall as a whole: advance = !out_valid || out_ready; in_ready = advance.
REQ-022 Under stall no sample SHALL be lost, duplicated or reordered; xs/ys SHALL hold stable while out_valid && !out_ready.
REQ-023 Full throughput (one sample/cycle) SHALL be sustained while out_ready = 1.
REQ-024 Simultaneous output drain and input accept in a full pipeline SHALL be permitted in the same cycle.

Reset
REQ-025 rst_n low SHALL asynchronously clear all stage valid bits, data registers, xs, ys to 0; out_valid = 0.
REQ-026 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-027 Reset mid-operation SHALL discard all in-flight samples; no partial output emitted.

Configuration
REQ-028 Macro MBRT_ROT_SAT_EN defined: each stage sum SHALL saturate to [-2^(CW-1), 2^(CW-1)-1] (sum computed CW+1 bits).
REQ-029 Macro MBRT_ROT_SAT_EN undefined: stage sums SHALL wrap modulo 2^CW, no saturation logic.

Structure
REQ-030 Package mbrt_pkg SHALL hold default CW/FW/SEGW/NSTG constants, shift function SEGW*(k+2), and sample-record typedef {x,y,xp,yp,phi,en,valid}.
REQ-031 One sub-module mbrt_rot_stage SHALL implement one stage (stage index parameter); top generates NSTG instances plus output register.

Verification (defaults CW=20 FW=12 SEGW=3 NSTG=3)
REQ-032 xc=0x10000, yc=0, xp=0, yp=256, phi all 1, en=111 -> xs=65532, ys=0, out_valid 4 cycles after transfer.
REQ-033 xc=100, yc=100, xp=yp=64, phi0=-1, phi1=phi2=0, en=111 -> xs=101, ys=99 (floor shift).
REQ-034 en=000, any phi -> xs=xc, ys=yc.
REQ-035 Offer 8 back-to-back samples, out_ready low 5 cycles mid-stream -> in_ready drops after pipeline fills, all 8 outputs in order, none duplicated.
REQ-036 xc=0x7FFFF, yp=-2048, phi0=3, phi1=phi2=0 -> xs=0x7FFFF with MBRT_ROT_SAT_EN, xs=0x8005F without.
REQ-037 rst_n low mid-stream (asynchronous, between edges) -> out_valid=0, xs=ys=0 immediately; no stale output after release.

Source files
------------

// File: rtl/mbrt_pkg.sv
// Shared defaults, per-stage shift helper and sample record for the mbrt rotation pipeline.
package mbrt_pkg;

  localparam int CW_DEF   = 20;
  localparam int FW_DEF   = 12;
  localparam int SEGW_DEF = 3;
  localparam int NSTG_DEF = 3;

  // Stage k scales its correction term down by SEGW*(k+2) bits.
  function automatic int rot_shift(input int segw, input int k);
    return segw * (k + 2);
  endfunction

  typedef struct packed {
    logic signed [CW_DEF-1:0]      x;
    logic signed [CW_DEF-1:0]      y;
    logic signed [FW_DEF-1:0]      xp;
    logic signed [FW_DEF-1:0]      yp;
    logic [NSTG_DEF*SEGW_DEF-1:0]  phi;
    logic [NSTG_DEF-1:0]           en;
    logic                          valid;
  } mbrt_sample_t;

endpackage

// File: rtl/mbrt_rot_stage.sv
// One rotation stage: applies a scaled fine-offset correction to (x,y) and registers the record.
// Sums saturate when MBRT_ROT_SAT_EN is defined, otherwise they wrap.
module mbrt_rot_stage
  import mbrt_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int FW   = FW_DEF,
  parameter int SEGW = SEGW_DEF,
  parameter int NSTG = NSTG_DEF,
  parameter int K    = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 advance,
  input  logic [2*CW+2*FW+NSTG*SEGW+NSTG:0]    rec_in,
  output logic [2*CW+2*FW+NSTG*SEGW+NSTG:0]    rec_out
);

  localparam int PW = FW + SEGW;
  localparam int SH = rot_shift(SEGW, K);

  typedef struct packed {
    logic signed [CW-1:0]   x;
    logic signed [CW-1:0]   y;
    logic signed [FW-1:0]   xp;
    logic signed [FW-1:0]   yp;
    logic [NSTG*SEGW-1:0]   phi;
    logic [NSTG-1:0]        en;
    logic                   valid;
  } rec_t;

  rec_t                   cur;
  rec_t                   nxt;
  rec_t                   rec_r;
  logic signed [SEGW-1:0] phi_k;
  logic signed [PW-1:0]   prod_yp;
  logic signed [PW-1:0]   prod_xp;
  logic signed [CW-1:0]   del_x;
  logic signed [CW-1:0]   del_y;
  logic signed [CW-1:0]   x_new;
  logic signed [CW-1:0]   y_new;

  assign cur   = rec_in;
  assign phi_k = cur.phi[K*SEGW +: SEGW];

  assign prod_yp = $signed({{SEGW{cur.yp[FW-1]}}, cur.yp}) * $signed({{FW{phi_k[SEGW-1]}}, phi_k});
  assign prod_xp = $signed({{SEGW{cur.xp[FW-1]}}, cur.xp}) * $signed({{FW{phi_k[SEGW-1]}}, phi_k});

  // Arithmetic shift floors toward minus infinity, then sign-extend to the word width.
  assign del_x = CW'(prod_yp >>> SH);
  assign del_y = CW'(prod_xp >>> SH);

`ifdef MBRT_ROT_SAT_EN
  function automatic logic signed [CW-1:0] sat(input logic signed [CW:0] s);
    if (s[CW] != s[CW-1]) begin
      return s[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    end else begin
      return s[CW-1:0];
    end
  endfunction

  assign x_new = sat({cur.x[CW-1], cur.x} - {del_x[CW-1], del_x});
  assign y_new = sat({cur.y[CW-1], cur.y} + {del_y[CW-1], del_y});
`else
  assign x_new = cur.x - del_x;
  assign y_new = cur.y + del_y;
`endif

  always_comb begin
    nxt = cur;
    if (cur.en[K]) begin
      nxt.x = x_new;
      nxt.y = y_new;
    end else begin
      nxt.x = cur.x;
      nxt.y = cur.y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_r <= '0;
    end else if (advance) begin
      rec_r <= nxt;
    end else begin
      rec_r <= rec_r;
    end
  end

  assign rec_out = rec_r;

endmodule

// File: rtl/mbrt_rot_pipe.sv
// Stallable pipeline: input register, NSTG rotation stages and an output register.
// Optional per-stage saturation is selected with the MBRT_ROT_SAT_EN macro.
module mbrt_rot_pipe
  import mbrt_pkg::*;
#(
  parameter int CW   = CW_DEF,
  parameter int FW   = FW_DEF,
  parameter int SEGW = SEGW_DEF,
  parameter int NSTG = NSTG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*CW+2*FW-1:0]    lut_data,
  input  logic [NSTG*SEGW-1:0]    phi_rot,
  input  logic [NSTG-1:0]         en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [CW-1:0]    xs,
  output logic signed [CW-1:0]    ys
);

  localparam int RW = 2*CW + 2*FW + NSTG*SEGW + NSTG + 1;

  typedef struct packed {
    logic signed [CW-1:0]   x;
    logic signed [CW-1:0]   y;
    logic signed [FW-1:0]   xp;
    logic signed [FW-1:0]   yp;
    logic [NSTG*SEGW-1:0]   phi;
    logic [NSTG-1:0]        en;
    logic                   valid;
  } rec_t;

  logic          advance;
  rec_t          in_rec;
  rec_t          head_r;
  rec_t          tail;
  logic [RW-1:0] link [0:NSTG];
  logic          unused_tail;

  // The whole pipe moves together; bubbles are squeezed out only by the output slot draining.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    in_rec       = '0;
    in_rec.x     = lut_data[2*CW+2*FW-1 -: CW];
    in_rec.y     = lut_data[CW+2*FW-1 -: CW];
    in_rec.xp    = lut_data[2*FW-1 -: FW];
    in_rec.yp    = lut_data[FW-1:0];
    in_rec.phi   = phi_rot;
    in_rec.en    = en;
    in_rec.valid = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= '0;
    end else if (advance) begin
      head_r <= in_rec;
    end else begin
      head_r <= head_r;
    end
  end

  assign link[0] = head_r;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    mbrt_rot_stage #(
      .CW   (CW),
      .FW   (FW),
      .SEGW (SEGW),
      .NSTG (NSTG),
      .K    (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (advance),
      .rec_in  (link[k]),
      .rec_out (link[k+1])
    );
  end

  assign tail        = link[NSTG];
  assign unused_tail = ^{tail.xp, tail.yp, tail.phi, tail.en};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      xs        <= '0;
      ys        <= '0;
    end else if (advance) begin
      out_valid <= tail.valid;
      xs        <= tail.x;
      ys        <= tail.y;
    end else begin
      out_valid <= out_valid;
      xs        <= xs;
      ys        <= ys;
    end
  end

endmodule
